// File: rtl/adc128_avg_mon_pkg.sv
// Shared definitions for the ADC128 averaging monitor: frame geometry and FSM encodings.
package adc128_avg_mon_pkg;

  localparam int NUM_CH   = 8;
  localparam int SAMPLE_W = 12;
  localparam int FRAME_W  = NUM_CH * SAMPLE_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACC,
    ST_UPD,
    ST_DONE
  } state_e;

endpackage

// File: rtl/adc128_avg_mon.sv
// Boxcar averager and debounced window monitor for 8-channel ADC128 frames.
// A single adder/comparator is time-multiplexed over the channels, one channel per clock.
module adc128_avg_mon
  import adc128_avg_mon_pkg::*;
#(
  parameter int AVG_LOG2 = 4,
  parameter int DEB_N    = 3
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  input  logic [FRAME_W-1:0]  ad_data_i,
  input  logic                ad_vld_i,
  input  logic [SAMPLE_W-1:0] thr_hi_i,
  input  logic [SAMPLE_W-1:0] thr_lo_i,
  output logic [FRAME_W-1:0]  avg_data_o,
  output logic                avg_vld_o,
  output logic [NUM_CH-1:0]   alarm_o,
  output logic                ovr_o
);

  localparam int         ACC_W      = SAMPLE_W + AVG_LOG2;
  localparam logic [6:0] FRAME_LAST = 7'((1 << AVG_LOG2) - 1);
  localparam logic [3:0] DEB_LAST   = 4'(DEB_N - 1);

  state_e              state_q, state_d;
  logic [2:0]          ch_q;
  logic [6:0]          frame_cnt_q;
  logic [SAMPLE_W-1:0] snap_q    [NUM_CH];
  logic [ACC_W-1:0]    acc_q     [NUM_CH];
  logic [3:0]          deb_cnt_q [NUM_CH];

  logic                last_ch;
  logic                last_frame;
  logic [ACC_W-1:0]    acc_sum;
  logic [SAMPLE_W-1:0] avg_cur;
  logic                out_win;

  // Shared datapath: everything below acts on the channel selected by ch_q.
  assign last_ch    = (ch_q == 3'(NUM_CH - 1));
  assign last_frame = (frame_cnt_q == FRAME_LAST);
  assign acc_sum    = acc_q[ch_q] + ACC_W'(snap_q[ch_q]);
  assign avg_cur    = acc_q[ch_q][AVG_LOG2 +: SAMPLE_W];
  assign out_win    = (avg_cur > thr_hi_i) || (avg_cur < thr_lo_i);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: state_d gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    if (!en_i) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: if (ad_vld_i) state_d = ST_ACC;
        ST_ACC:  if (last_ch)  state_d = last_frame ? ST_UPD : ST_IDLE;
        ST_UPD:  if (last_ch)  state_d = ST_DONE;
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    avg_vld_o = (state_q == ST_DONE);
  end

  // NOTE: the small per-channel arrays are reset explicitly; they must read as zero after reset.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ch_q        <= '0;
      frame_cnt_q <= '0;
      avg_data_o  <= '0;
      alarm_o     <= '0;
      ovr_o       <= 1'b0;
      for (int n = 0; n < NUM_CH; n++) begin
        snap_q[n]    <= '0;
        acc_q[n]     <= '0;
        deb_cnt_q[n] <= '0;
      end
    end else if (!en_i) begin
      // Abort: drop all partial work, keep the last published averages and alarms.
      ch_q        <= '0;
      frame_cnt_q <= '0;
      ovr_o       <= 1'b0;
      for (int n = 0; n < NUM_CH; n++) begin
        acc_q[n]     <= '0;
        deb_cnt_q[n] <= '0;
      end
    end else begin
      if (ad_vld_i && (state_q != ST_IDLE)) ovr_o <= 1'b1;

      unique case (state_q)
        ST_IDLE: begin
          if (ad_vld_i) begin
            ch_q <= '0;
            for (int n = 0; n < NUM_CH; n++) begin
              snap_q[n] <= ad_data_i[n*SAMPLE_W +: SAMPLE_W];
            end
          end
        end
        ST_ACC: begin
          acc_q[ch_q] <= acc_sum;
          ch_q        <= ch_q + 3'd1;
          if (last_ch && !last_frame) frame_cnt_q <= frame_cnt_q + 7'd1;
        end
        ST_UPD: begin
          avg_data_o[ch_q*SAMPLE_W +: SAMPLE_W] <= avg_cur;
          acc_q[ch_q] <= '0;
          ch_q        <= ch_q + 3'd1;
          if (last_ch) frame_cnt_q <= '0;
          // Toggle only after DEB_N consecutive disagreeing averages.
          if (out_win != alarm_o[ch_q]) begin
            if (deb_cnt_q[ch_q] == DEB_LAST) begin
              alarm_o[ch_q]   <= out_win;
              deb_cnt_q[ch_q] <= '0;
            end else begin
              deb_cnt_q[ch_q] <= deb_cnt_q[ch_q] + 4'd1;
            end
          end else begin
            deb_cnt_q[ch_q] <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adc128_avg_mon.sv
// Directed self-checking bench for adc128_avg_mon (AVG_LOG2=2, DEB_N=3).
module tb_adc128_avg_mon;
  import adc128_avg_mon_pkg::*;

  logic                clk_i = 1'b0;
  logic                rst_i;
  logic                en_i;
  logic [FRAME_W-1:0]  ad_data_i;
  logic                ad_vld_i;
  logic [SAMPLE_W-1:0] thr_hi_i;
  logic [SAMPLE_W-1:0] thr_lo_i;
  logic [FRAME_W-1:0]  avg_data_o;
  logic                avg_vld_o;
  logic [NUM_CH-1:0]   alarm_o;
  logic                ovr_o;

  int n_cmp  = 0;
  int n_fail = 0;

  adc128_avg_mon #(.AVG_LOG2(2), .DEB_N(3)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .en_i       (en_i),
    .ad_data_i  (ad_data_i),
    .ad_vld_i   (ad_vld_i),
    .thr_hi_i   (thr_hi_i),
    .thr_lo_i   (thr_lo_i),
    .avg_data_o (avg_data_o),
    .avg_vld_o  (avg_vld_o),
    .alarm_o    (alarm_o),
    .ovr_o      (ovr_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send_frame(input logic [95:0] d);
    ad_data_i = d;
    ad_vld_i  = 1'b1;
    tick();
    ad_vld_i  = 1'b0;
  endtask

  function automatic logic [95:0] all_ch(input logic [11:0] v);
    return {8{v}};
  endfunction

  function automatic logic [95:0] set_ch(input logic [95:0] f, input int n, input logic [11:0] v);
    logic [95:0] r;
    r = f;
    r[n*12 +: 12] = v;
    return r;
  endfunction

  // Called right after the last frame's accept edge: done pulse must appear 16 edges later, 1 cycle wide.
  task automatic wait_done(input string tag);
    int lat;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (avg_vld_o === 1'b1) begin
        lat = i;
        break;
      end
    end
    check({tag, "_lat"}, 96'(lat), 96'(16));
    tick();
    check({tag, "_pulse"}, 96'(avg_vld_o), 96'(0));
    idle(2);
  endtask

  task automatic run_block(input string tag, input logic [95:0] f0, input logic [95:0] f1,
                           input logic [95:0] f2, input logic [95:0] f3);
    send_frame(f0); idle(12);
    send_frame(f1); idle(12);
    send_frame(f2); idle(12);
    send_frame(f3);
    wait_done(tag);
  endtask

  initial begin
    logic [95:0] f;
    int vcnt;

    rst_i = 1'b0; en_i = 1'b1; ad_vld_i = 1'b0; ad_data_i = '0;
    thr_hi_i = 12'h800; thr_lo_i = 12'h100;
    idle(2);
    check("rst_avg",   avg_data_o,       96'(0));
    check("rst_vld",   96'(avg_vld_o),   96'(0));
    check("rst_alarm", 96'(alarm_o),     96'(0));
    check("rst_ovr",   96'(ovr_o),       96'(0));
    rst_i = 1'b1;
    idle(2);

    // 1: uniform 0x100 frames
    f = all_ch(12'h100);
    run_block("t1", f, f, f, f);
    check("t1_avg",   avg_data_o,   all_ch(12'h100));
    check("t1_alarm", 96'(alarm_o), 96'(0));

    // 2: truncation on ch0 (sum 10 -> 2) and full-scale ch7 without overflow
    f = set_ch(all_ch(12'h200), 7, 12'hFFF);
    run_block("t2", set_ch(f, 0, 12'h001), set_ch(f, 0, 12'h002),
                    set_ch(f, 0, 12'h003), set_ch(f, 0, 12'h004));
    check("t2_avg", avg_data_o, {12'hFFF, {6{12'h200}}, 12'h002});

    // 3: debounce on ch3
    f = set_ch(all_ch(12'h200), 3, 12'h900);
    run_block("t3a", f, f, f, f);
    check("t3a_alarm", 96'(alarm_o), 96'(8'h00));
    check("t3a_avg",   avg_data_o,   f);
    run_block("t3b", f, f, f, f);
    check("t3b_alarm", 96'(alarm_o), 96'(8'h00));
    run_block("t3c", f, f, f, f);
    check("t3c_alarm", 96'(alarm_o), 96'(8'h08));
    f = set_ch(all_ch(12'h200), 3, 12'h400);
    run_block("t3d", f, f, f, f);
    check("t3d_alarm", 96'(alarm_o), 96'(8'h08));
    run_block("t3e", f, f, f, f);
    check("t3e_alarm", 96'(alarm_o), 96'(8'h08));
    run_block("t3f", f, f, f, f);
    check("t3f_alarm", 96'(alarm_o), 96'(8'h00));
    f = set_ch(all_ch(12'h200), 3, 12'h900);
    run_block("t3g", f, f, f, f);
    check("t3g_alarm", 96'(alarm_o), 96'(8'h00));
    f = set_ch(all_ch(12'h200), 3, 12'h400);
    run_block("t3h", f, f, f, f);
    check("t3h_alarm", 96'(alarm_o), 96'(8'h00));
    f = set_ch(all_ch(12'h200), 3, 12'h900);
    run_block("t3i", f, f, f, f);
    check("t3i_alarm", 96'(alarm_o), 96'(8'h00));

    // 4: frame arriving 5 cycles into ACC is dropped and flagged
    check("t4_ovr_before", 96'(ovr_o), 96'(0));
    f = all_ch(12'h300);
    send_frame(f); idle(4);
    send_frame(all_ch(12'hFFF)); idle(8);
    check("t4_ovr_set", 96'(ovr_o), 96'(1));
    send_frame(f); idle(12);
    send_frame(f); idle(12);
    send_frame(f);
    wait_done("t4");
    check("t4_avg",        avg_data_o,  all_ch(12'h300));
    check("t4_ovr_sticky", 96'(ovr_o),  96'(1));

    // 5: disable in UPD at ch4; slots 0..3 already written hold
    f = all_ch(12'h500);
    send_frame(f); idle(12);
    send_frame(f); idle(12);
    send_frame(f); idle(12);
    send_frame(f); idle(12);
    en_i = 1'b0;
    vcnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (avg_vld_o === 1'b1) vcnt++;
    end
    check("t5_no_vld", 96'(vcnt),  96'(0));
    check("t5_ovr_clr", 96'(ovr_o), 96'(0));
    check("t5_hold", avg_data_o, {{4{12'h300}}, {4{12'h500}}});
    en_i = 1'b1;
    idle(2);
    f = all_ch(12'h600);
    run_block("t5", f, f, f, f);
    check("t5_avg", avg_data_o, all_ch(12'h600));
    check("t5_ovr", 96'(ovr_o), 96'(0));

    // Inverted window (lo > hi): every value out-of-window
    thr_hi_i = 12'h000; thr_lo_i = 12'hFFF;
    run_block("inv1", f, f, f, f);
    check("inv1_alarm", 96'(alarm_o), 96'(8'h00));
    run_block("inv2", f, f, f, f);
    run_block("inv3", f, f, f, f);
    check("inv3_alarm", 96'(alarm_o), 96'(8'hFF));
    thr_hi_i = 12'h800; thr_lo_i = 12'h100;

    // 6: async reset mid-ACC
    send_frame(all_ch(12'h700)); idle(3);
    #2 rst_i = 1'b0;
    #1;
    check("t6_avg",   avg_data_o,     96'(0));
    check("t6_alarm", 96'(alarm_o),   96'(0));
    check("t6_vld",   96'(avg_vld_o), 96'(0));
    check("t6_ovr",   96'(ovr_o),     96'(0));
    #2 rst_i = 1'b1;
    idle(2);
    f = all_ch(12'h123);
    run_block("t6", f, f, f, f);
    check("t6_avg_after", avg_data_o,   all_ch(12'h123));
    check("t6_alarm_after", 96'(alarm_o), 96'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
